// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: sequences fifo_tx into the UART transmitter, commits clean
// received frames into fifo_rx and streams fifo_rx to the host (valid/ready).
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_tx_en, i_rx_en, i_clr_stats    host controls
//   i_tx_empty, i_tx_busy, i_tx_done fifo_tx / transmitter status
//   o_tx_rd_en, o_tx_start           fifo_tx pop, transmitter launch pulses
//   i_rx_full, i_rx_empty            fifo_rx status flags
//   i_rx_done, i_framing_error_flag,
//   i_parity_error_flag              receiver frame-complete and error flags
//   i_rx_fifo_data                   fifo_rx read data (cycle after pop)
//   o_rx_start, o_rx_wr_en, o_rx_rd_en  receiver enable, fifo_rx push/pop
//   o_m_data, o_m_valid, i_m_ready   host byte stream
//   o_tx_timeout_err                 sticky TX watchdog flag
//   o_frame_err_cnt, o_parity_err_cnt, o_overrun_cnt  saturating statistics
module uart_link_ctrl #(
    parameter int data_wd    = 8,
    parameter int cnt_wd     = 16,
    parameter int tx_timeout = 70000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tx_en,
    input  logic               i_rx_en,
    input  logic               i_clr_stats,
    input  logic               i_tx_empty,
    input  logic               i_tx_busy,
    input  logic               i_tx_done,
    output logic               o_tx_rd_en,
    output logic               o_tx_start,
    input  logic               i_rx_full,
    input  logic               i_rx_empty,
    input  logic               i_rx_done,
    input  logic               i_framing_error_flag,
    input  logic               i_parity_error_flag,
    input  logic [data_wd-1:0] i_rx_fifo_data,
    output logic               o_rx_start,
    output logic               o_rx_wr_en,
    output logic               o_rx_rd_en,
    output logic [data_wd-1:0] o_m_data,
    output logic               o_m_valid,
    input  logic               i_m_ready,
    output logic               o_tx_timeout_err,
    output logic [cnt_wd-1:0]  o_frame_err_cnt,
    output logic [cnt_wd-1:0]  o_parity_err_cnt,
    output logic [cnt_wd-1:0]  o_overrun_cnt
);

    localparam int WD_W = $clog2(tx_timeout + 1);

    typedef enum logic [1:0] {
        T_IDLE,
        T_LOAD,
        T_WAIT
    } tx_state_t;

    tx_state_t r_tx_state;
    tx_state_t w_tx_state_nxt;

    logic [WD_W-1:0] r_wdog;
    logic            r_tx_start;
    logic            r_tx_timeout_err;
    logic            w_tx_launch;
    logic            w_wdog_expire;
    logic            w_tx_rd_en;
    logic            w_tx_start_nxt;
    logic            w_wdog_load;
    logic            w_wdog_dec;

    assign w_tx_launch   = i_tx_en && !i_tx_empty && !i_tx_busy;
    // Expires on the last watchdog count unless tx_done lands in that cycle.
    assign w_wdog_expire = (r_tx_state == T_WAIT) && !i_tx_done
                           && (r_wdog == WD_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_state <= T_IDLE;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        unique case (r_tx_state)
            T_IDLE: begin
                if (w_tx_launch) begin
                    w_tx_state_nxt = T_LOAD;
                end
            end
            T_LOAD: begin
                w_tx_state_nxt = T_WAIT;
            end
            T_WAIT: begin
                if (i_tx_done || w_wdog_expire) begin
                    w_tx_state_nxt = T_IDLE;
                end
            end
            default: begin
                w_tx_state_nxt = T_IDLE;
            end
        endcase
    end

    // Pop is combinational so the launch costs no idle cycle; tx_start is
    // registered out of T_LOAD, landing 2 cycles after the pop.
    always_comb begin
        w_tx_rd_en     = 1'b0;
        w_tx_start_nxt = 1'b0;
        w_wdog_load    = 1'b0;
        w_wdog_dec     = 1'b0;
        unique case (r_tx_state)
            T_IDLE: w_tx_rd_en = !i_rst && w_tx_launch;
            T_LOAD: begin
                w_tx_start_nxt = 1'b1;
                w_wdog_load    = 1'b1;
            end
            T_WAIT: w_wdog_dec = (r_wdog != '0);
            default: w_tx_rd_en = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_start       <= 1'b0;
            r_wdog           <= '0;
            r_tx_timeout_err <= 1'b0;
        end else begin
            r_tx_start <= w_tx_start_nxt;
            if (w_wdog_load) begin
                r_wdog <= WD_W'(tx_timeout);
            end else if (w_wdog_dec) begin
                r_wdog <= r_wdog - WD_W'(1);
            end
            if (i_clr_stats) begin
                r_tx_timeout_err <= 1'b0;
            end else if (w_wdog_expire) begin
                r_tx_timeout_err <= 1'b1;
            end
        end
    end

    logic r_rx_start;
    logic w_frame_hit;
    logic w_parity_hit;
    logic w_overrun_hit;
    logic w_rx_wr_en;

    // Framing error outranks parity; overrun only counts otherwise-good frames.
    assign w_frame_hit   = i_rx_done && i_framing_error_flag;
    assign w_parity_hit  = i_rx_done && !i_framing_error_flag
                           && i_parity_error_flag;
    assign w_overrun_hit = i_rx_done && !i_framing_error_flag
                           && !i_parity_error_flag && i_rx_full;
    assign w_rx_wr_en    = !i_rst && i_rx_done && !i_framing_error_flag
                           && !i_parity_error_flag && !i_rx_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_start <= 1'b0;
        end else begin
            r_rx_start <= i_rx_en;
        end
    end

    function automatic logic [cnt_wd-1:0] sat_inc(
        input logic [cnt_wd-1:0] v
    );
        return (&v) ? v : v + cnt_wd'(1);
    endfunction

    logic [cnt_wd-1:0] r_frame_err_cnt;
    logic [cnt_wd-1:0] r_parity_err_cnt;
    logic [cnt_wd-1:0] r_overrun_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_stats) begin
            r_frame_err_cnt  <= '0;
            r_parity_err_cnt <= '0;
            r_overrun_cnt    <= '0;
        end else begin
            if (w_frame_hit) begin
                r_frame_err_cnt <= sat_inc(r_frame_err_cnt);
            end
            if (w_parity_hit) begin
                r_parity_err_cnt <= sat_inc(r_parity_err_cnt);
            end
            if (w_overrun_hit) begin
                r_overrun_cnt <= sat_inc(r_overrun_cnt);
            end
        end
    end

    logic               r_rd_pend;
    logic               r_m_valid;
    logic [data_wd-1:0] r_m_data;
    logic               w_rx_rd_en;

    // One byte in flight at a time: pop, capture next cycle, hold until taken.
    assign w_rx_rd_en = !i_rst && !i_rx_empty && !r_m_valid && !r_rd_pend;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_pend <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            r_rd_pend <= w_rx_rd_en;
            if (r_rd_pend) begin
                r_m_data  <= i_rx_fifo_data;
                r_m_valid <= 1'b1;
            end else if (r_m_valid && i_m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign o_tx_rd_en       = w_tx_rd_en;
    assign o_tx_start       = r_tx_start;
    assign o_tx_timeout_err = r_tx_timeout_err;
    assign o_rx_start       = r_rx_start;
    assign o_rx_wr_en       = w_rx_wr_en;
    assign o_rx_rd_en       = w_rx_rd_en;
    assign o_m_data         = r_m_data;
    assign o_m_valid        = r_m_valid;
    assign o_frame_err_cnt  = r_frame_err_cnt;
    assign o_parity_err_cnt = r_parity_err_cnt;
    assign o_overrun_cnt    = r_overrun_cnt;

endmodule
